producer_arbiter: RTL and testbench

Scheduler that shares the CDC FIFO write port (data_1/data_1_en) between the fibonacci and timer producers. It replaces the ad-hoc top-level FSM.
- Tracks which producers are active.
- Issues one-word requests round-robin and waits for each producer's valid, with a timeout.
- Writes the captured word only while the FIFO is not full.
- Drains the FIFO on stop.

---
 rtl/producer_arbiter_pkg.sv | 41 ++++
 rtl/producer_arbiter_wait_timer.sv | 47 ++++
 rtl/producer_arbiter.sv | 224 ++++++++++++++++++++++
 tb/tb_producer_arbiter.sv | 344 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/producer_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : producer_arbiter_pkg
//  Purpose  : Shared state codes, source ids, defaults and the round-robin
//             helper used by the producer arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package producer_arbiter_pkg;

  // FSM state codes; the raw code is also exported for LED display
  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_ISSUE = 3'd1;
  localparam state_t S_WAIT  = 3'd2;
  localparam state_t S_WRITE = 3'd3;
  localparam state_t S_STALL = 3'd4;
  localparam state_t S_DRAIN = 3'd5;

  // Producer ids as carried on the grant output
  localparam logic SRC_FIB = 1'b0;
  localparam logic SRC_TMR = 1'b1;

  localparam int DEFAULT_WIDTH   = 16;
  localparam int DEFAULT_TIMEOUT = 64;

  // Pick the next source: alternate when both are active, otherwise take
  // whichever one is active (callers only use this when at least one is).
  function automatic logic rr_pick(input logic act_f, input logic act_t,
                                   input logic last);
    if (act_f && act_t) begin
      return ~last;
    end else if (act_t) begin
      return SRC_TMR;
    end else begin
      return SRC_FIB;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/producer_arbiter_wait_timer.sv
`default_nettype none
// ============================================================================
//  Module   : arb_wait_timer
//  Purpose  : Clearable up-counter with a terminal-count flag. Counts the
//             cycles spent waiting for the granted producer's valid and
//             saturates at TIMEOUT-1 so the flag stays asserted.
//  Revision : 1.0  initial release
// ============================================================================
module arb_wait_timer #(
  parameter int TIMEOUT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tc
);

  localparam int            CW     = $clog2(TIMEOUT);
  localparam logic [CW-1:0] TC_VAL = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  assign tc = (count_q == TC_VAL);

  // Clear wins over count; hold once terminal count is reached
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && !tc) begin
      count_d = count_q + CW'(1);
    end
  end

  // Counter register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/producer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : producer_arbiter
//  Purpose  : Shares the CDC FIFO write port between the fibonacci and timer
//             producers. Issues one-word requests round-robin, waits for the
//             granted valid with a timeout, writes only when the FIFO has
//             room and drains the FIFO after stop.
//  Options  : ARB_STATS_EN - adds f_count / t_count / to_count statistics.
//  Revision : 1.0  initial release
// ============================================================================
module producer_arbiter
  import producer_arbiter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_f,
  input  logic             start_t,
  input  logic             stop,
  input  logic             f_valid,
  input  logic [WIDTH-1:0] f_data,
  input  logic             t_valid,
  input  logic [WIDTH-1:0] t_data,
  input  logic             buffer_full,
  input  logic             buffer_empty,
  input  logic             data_2_valid,
  output logic             f_en,
  output logic             t_en,
  output logic [WIDTH-1:0] data_1,
  output logic             data_1_en,
  output logic             grant,
  output logic [2:0]       state,
  output logic             timeout_err
`ifdef ARB_STATS_EN
  ,
  output logic [15:0]      f_count,
  output logic [15:0]      t_count,
  output logic [15:0]      to_count
`endif
);

  state_t           state_q, state_d;
  logic             grant_q, grant_d;
  logic             last_q, last_d;
  logic             act_f_q, act_f_d;
  logic             act_t_q, act_t_d;
  logic             stop_pend_q, stop_pend_d;
  logic [WIDTH-1:0] data_1_q, data_1_d;

  logic             w_tc;
  logic             w_granted_valid;
  logic [WIDTH-1:0] w_granted_data;
  logic             w_drain_done;

  // Only the granted producer's handshake is looked at; the other is ignored
  assign w_granted_valid = (grant_q == SRC_TMR) ? t_valid : f_valid;
  assign w_granted_data  = (grant_q == SRC_TMR) ? t_data  : f_data;
  assign w_drain_done    = (state_q == S_DRAIN) && buffer_empty && !data_2_valid;

  arb_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk (clk),
    .rst (rst),
    .clr (state_q == S_ISSUE),
    .en  (state_q == S_WAIT),
    .tc  (w_tc)
  );

  // State and grant registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      grant_q <= SRC_FIB;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic; the grant is chosen on the way out of IDLE
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    case (state_q)
      S_IDLE: begin
        if (stop_pend_q) begin
          state_d = S_DRAIN;
        end else if (buffer_full) begin
          state_d = S_STALL;
        end else if (act_f_q || act_t_q) begin
          state_d = S_ISSUE;
          grant_d = rr_pick(act_f_q, act_t_q, last_q);
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        // A valid arriving on the terminal-count cycle still wins
        if (w_granted_valid) begin
          state_d = S_WRITE;
        end else if (w_tc) begin
          state_d = S_IDLE;
        end
      end
      S_WRITE, S_STALL: begin
        if (!buffer_full) begin
          state_d = stop_pend_q ? S_DRAIN : S_IDLE;
        end
      end
      S_DRAIN: begin
        if (w_drain_done) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Moore/Mealy outputs: request pulses, write strobe, timeout pulse
  always_comb begin
    f_en        = 1'b0;
    t_en        = 1'b0;
    data_1_en   = 1'b0;
    timeout_err = 1'b0;
    case (state_q)
      S_ISSUE: begin
        f_en = (grant_q == SRC_FIB);
        t_en = (grant_q == SRC_TMR);
      end
      S_WAIT:  timeout_err = w_tc && !w_granted_valid;
      S_WRITE: data_1_en   = !buffer_full;
      default: ;
    endcase
  end

  assign data_1 = data_1_q;
  assign grant  = grant_q;
  assign state  = state_q;

  // Source-activity flags, pending stop, round-robin memory and data word
  always_comb begin
    act_f_d     = act_f_q;
    act_t_d     = act_t_q;
    stop_pend_d = stop_pend_q;
    last_d      = last_q;
    data_1_d    = data_1_q;

    // stop overrides any start in the same cycle
    if (stop) begin
      stop_pend_d = 1'b1;
      act_f_d     = 1'b0;
      act_t_d     = 1'b0;
    end else begin
      if (state_q != S_DRAIN) begin
        if (start_f) act_f_d = 1'b1;
        if (start_t) act_t_d = 1'b1;
      end
      if (w_drain_done) stop_pend_d = 1'b0;
    end

    if ((state_q == S_WAIT) && w_granted_valid) begin
      data_1_d = w_granted_data;
    end

    // A request is finished either by its write or by its timeout
    if (data_1_en || timeout_err) begin
      last_d = grant_q;
    end
  end

  // Datapath and flag registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      act_f_q     <= 1'b0;
      act_t_q     <= 1'b0;
      stop_pend_q <= 1'b0;
      last_q      <= SRC_TMR;
      data_1_q    <= '0;
    end else begin
      act_f_q     <= act_f_d;
      act_t_q     <= act_t_d;
      stop_pend_q <= stop_pend_d;
      last_q      <= last_d;
      data_1_q    <= data_1_d;
    end
  end

`ifdef ARB_STATS_EN
  logic [15:0] f_count_q, f_count_d;
  logic [15:0] t_count_q, t_count_d;
  logic [15:0] to_count_q, to_count_d;

  // Per-source write counts and timeout count, all wrapping
  always_comb begin
    f_count_d  = f_count_q;
    t_count_d  = t_count_q;
    to_count_d = to_count_q;
    if (data_1_en && (grant_q == SRC_FIB)) f_count_d = f_count_q + 16'd1;
    if (data_1_en && (grant_q == SRC_TMR)) t_count_d = t_count_q + 16'd1;
    if (timeout_err) to_count_d = to_count_q + 16'd1;
  end

  // Statistics registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_count_q  <= '0;
      t_count_q  <= '0;
      to_count_q <= '0;
    end else begin
      f_count_q  <= f_count_d;
      t_count_q  <= t_count_d;
      to_count_q <= to_count_d;
    end
  end

  assign f_count  = f_count_q;
  assign t_count  = t_count_q;
  assign to_count = to_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_producer_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_producer_arbiter
//  Purpose  : Self-checking bench for producer_arbiter. A transaction-level
//             model tracks the arbiter's phase, flags and last word and is
//             compared against the DUT every cycle; directed scenarios add
//             hand-computed literal expectations.
//  Revision : 1.0  initial release
// ============================================================================
module tb_producer_arbiter;

  localparam int WIDTH   = 16;
  localparam int TIMEOUT = 64;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start_f = 1'b0, start_t = 1'b0, stop = 1'b0;
  logic             f_valid = 1'b0, t_valid = 1'b0;
  logic [WIDTH-1:0] f_data = '0, t_data = '0;
  logic             buffer_full = 1'b0, buffer_empty = 1'b1, data_2_valid = 1'b0;
  logic             f_en, t_en, data_1_en, grant, timeout_err;
  logic [WIDTH-1:0] data_1;
  logic [2:0]       state;
`ifdef ARB_STATS_EN
  logic [15:0]      f_count, t_count, to_count;
`endif

  producer_arbiter #(
    .WIDTH   (WIDTH),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_f      (start_f),
    .start_t      (start_t),
    .stop         (stop),
    .f_valid      (f_valid),
    .f_data       (f_data),
    .t_valid      (t_valid),
    .t_data       (t_data),
    .buffer_full  (buffer_full),
    .buffer_empty (buffer_empty),
    .data_2_valid (data_2_valid),
    .f_en         (f_en),
    .t_en         (t_en),
    .data_1       (data_1),
    .data_1_en    (data_1_en),
    .grant        (grant),
    .state        (state),
    .timeout_err  (timeout_err)
`ifdef ARB_STATS_EN
    ,
    .f_count      (f_count),
    .t_count      (t_count),
    .to_count     (to_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int cyc      = 0;

  // Stimulus knobs and producer responders
  bit               rand_mode = 1'b0;
  int               f_lat = 0, t_lat = 0;   // 0 = never answer
  int               f_cnt = 0, t_cnt = 0;
  logic [WIDTH-1:0] f_next = '0, t_next = '0;

  // Snapshot of the DUT outputs for the cycle that just ended
  logic [2:0]       s_state;
  logic             s_grant, s_f_en, s_t_en, s_d1en, s_to;
  logic [WIDTH-1:0] s_d1;

  // Behavioural model
  int               m_state;
  bit               m_act_f, m_act_t, m_stop, m_grant, m_last;
  int               m_issue_cyc;
  logic [WIDTH-1:0] m_word;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", name, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0; m_act_f = 0; m_act_t = 0; m_stop = 0;
    m_grant = 0; m_last = 1; m_issue_cyc = 0; m_word = '0;
  endtask

  task automatic model_compare();
    bit gv;
    gv = m_grant ? t_valid : f_valid;
    check("state", 32'(state), 32'(m_state));
    check("grant", 32'(grant), 32'(m_grant));
    check("f_en", 32'(f_en), 32'(m_state == 1 && !m_grant));
    check("t_en", 32'(t_en), 32'(m_state == 1 && m_grant));
    check("data_1", 32'(data_1), 32'(m_word));
    check("data_1_en", 32'(data_1_en), 32'(m_state == 3 && !buffer_full));
    check("timeout_err", 32'(timeout_err),
          32'(m_state == 2 && !gv && (cyc - m_issue_cyc) == TIMEOUT));
  endtask

  // Advance the model over one rising edge using the inputs of this cycle
  task automatic model_step();
    bit               gv;
    logic [WIDTH-1:0] gd;
    int               nxt;
    gv  = m_grant ? t_valid : f_valid;
    gd  = m_grant ? t_data  : f_data;
    nxt = m_state;
    case (m_state)
      0: begin
        if (m_stop) nxt = 5;
        else if (buffer_full) nxt = 4;
        else if (m_act_f || m_act_t) begin
          nxt = 1;
          m_grant = (m_act_f && m_act_t) ? !m_last : m_act_t;
        end
      end
      1: begin nxt = 2; m_issue_cyc = cyc; end
      2: begin
        if (gv) begin m_word = gd; nxt = 3; end
        else if ((cyc - m_issue_cyc) == TIMEOUT) begin m_last = m_grant; nxt = 0; end
      end
      3: if (!buffer_full) begin m_last = m_grant; nxt = m_stop ? 5 : 0; end
      4: if (!buffer_full) nxt = m_stop ? 5 : 0;
      5: if (buffer_empty && !data_2_valid) nxt = 0;
      default: nxt = 0;
    endcase
    if (stop) begin
      m_stop = 1; m_act_f = 0; m_act_t = 0;
    end else begin
      if (m_state != 5) begin
        if (start_f) m_act_f = 1;
        if (start_t) m_act_t = 1;
      end
      if (m_state == 5 && nxt == 0) m_stop = 0;
    end
    m_state = nxt;
  endtask

  // One clock cycle: compare at negedge, step model at posedge, drive at +1
  task automatic cycle();
    @(negedge clk);
    if (!rst) model_compare();
    s_state = state; s_grant = grant; s_f_en = f_en; s_t_en = t_en;
    s_d1 = data_1; s_d1en = data_1_en; s_to = timeout_err;
    if (f_en) f_cnt = rand_mode ? int'($urandom_range(0, 6)) : f_lat;
    if (t_en) t_cnt = rand_mode ? int'($urandom_range(0, 6)) : t_lat;
    @(posedge clk);
    if (rst) model_reset(); else model_step();
    cyc++;
    #1;
    start_f = 0; start_t = 0; stop = 0;
    f_valid = 0; t_valid = 0;
    if (f_cnt > 0) begin
      f_cnt--;
      if (f_cnt == 0) begin f_valid = 1; f_data = f_next; f_next++; end
    end
    if (t_cnt > 0) begin
      t_cnt--;
      if (t_cnt == 0) begin t_valid = 1; t_data = t_next; t_next++; end
    end
    if (rand_mode) begin
      start_f = ($urandom_range(0, 99) < 3);
      start_t = ($urandom_range(0, 99) < 3);
      stop    = ($urandom_range(0, 99) < 1);
      if (!f_valid && $urandom_range(0, 99) < 8) begin f_valid = 1; f_data = WIDTH'($urandom); end
      if (!t_valid && $urandom_range(0, 99) < 8) begin t_valid = 1; t_data = WIDTH'($urandom); end
      buffer_full  = ($urandom_range(0, 99) < 20);
      buffer_empty = ($urandom_range(0, 99) < 70);
      data_2_valid = ($urandom_range(0, 99) < 30);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(state), 32'd0);
    check({tag, "_f_en"}, 32'(f_en), 32'd0);
    check({tag, "_t_en"}, 32'(t_en), 32'd0);
    check({tag, "_data_1_en"}, 32'(data_1_en), 32'd0);
    check({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    check({tag, "_data_1"}, 32'(data_1), 32'd0);
    check({tag, "_grant"}, 32'(grant), 32'd0);
  endtask

  task automatic do_reset();
    rst = 1; model_reset();
    start_f = 0; start_t = 0; stop = 0; f_valid = 0; t_valid = 0;
    buffer_full = 0; buffer_empty = 1; data_2_valid = 0;
    f_cnt = 0; t_cnt = 0;
    repeat (2) @(posedge clk);
    #1;
    check_all_zero("reset");
    rst = 0;
  endtask

  // Run until the requested source's enable is seen; bounded
  task automatic wait_req(input bit tmr, input string tag);
    int n;
    n = 0;
    do begin cycle(); n++; end while (!(tmr ? s_t_en : s_f_en) && n < 40);
    check({tag, "_req_seen"}, 32'(tmr ? s_t_en : s_f_en), 32'd1);
  endtask

  initial begin
    int   n, nw;
    int   exp_src [4];
    logic [WIDTH-1:0] exp_dat [4];
    int   got_src [4];
    logic [WIDTH-1:0] got_dat [4];

    // ---- single fibonacci word, valid 2 cycles after f_en ----
    do_reset();
    start_f = 1; f_lat = 2; f_next = 16'h0005;
    n = 0;
    do begin cycle(); n++; end while (!s_f_en && n < 40);
    check("t1_issue_lat", 32'(n), 32'd3);
    check("t1_grant", 32'(s_grant), 32'd0);
    n = 0;
    do begin cycle(); n++; end while (!s_d1en && n < 40);
    check("t1_write_lat", 32'(n), 32'd3);
    check("t1_data", 32'(s_d1), 32'h0005);
    cycle();
    check("t1_single_write", 32'(s_d1en), 32'd0);
    check("t1_back_idle", 32'(s_state), 32'd0);
    cycle();
    check("t1_next_req", 32'(s_f_en), 32'd1);

    // ---- both sources: strict alternation starting with fibonacci ----
    do_reset();
    start_f = 1; start_t = 1; f_lat = 1; t_lat = 1;
    f_next = 16'hA000; t_next = 16'hB000;
    exp_src = '{0, 1, 0, 1};
    exp_dat = '{16'hA000, 16'hB000, 16'hA001, 16'hB001};
    nw = 0; n = 0;
    while (nw < 4 && n < 80) begin
      cycle(); n++;
      if (s_d1en) begin got_src[nw] = int'(s_grant); got_dat[nw] = s_d1; nw++; end
    end
    check("t2_write_count", 32'(nw), 32'd4);
    for (int i = 0; i < nw; i++) begin
      check("t2_src", 32'(got_src[i]), 32'(exp_src[i]));
      check("t2_data", 32'(got_dat[i]), 32'(exp_dat[i]));
    end

    // ---- FIFO full for 5 cycles of WRITE ----
    do_reset();
    start_f = 1; f_lat = 1; f_next = 16'h1234;
    wait_req(1'b0, "t3");
    cycle();                       // now in WRITE
    buffer_full = 1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("t3_hold_state", 32'(s_state), 32'd3);
      check("t3_hold_no_wr", 32'(s_d1en), 32'd0);
      check("t3_hold_data", 32'(s_d1), 32'h1234);
    end
    buffer_full = 0;
    cycle();
    check("t3_write", 32'(s_d1en), 32'd1);
    check("t3_write_data", 32'(s_d1), 32'h1234);
    cycle();
    check("t3_once", 32'(s_d1en), 32'd0);

    // ---- timer never answers: timeout 64 cycles after t_en ----
    do_reset();
    start_t = 1; t_lat = 0;
    wait_req(1'b1, "t4");
    n = 0; nw = 0;
    do begin cycle(); n++; if (s_d1en) nw++; end while (!s_to && n < 200);
    check("t4_timeout_lat", 32'(n), 32'd64);
    check("t4_timeout_state", 32'(s_state), 32'd2);
    check("t4_no_write", 32'(nw), 32'd0);
    cycle();
    check("t4_idle_after", 32'(s_state), 32'd0);

    // ---- stop during WAIT: word completes, then DRAIN ----
    do_reset();
    start_f = 1; f_lat = 4; f_next = 16'h0BEE;
    wait_req(1'b0, "t5");
    stop = 1; buffer_empty = 0; data_2_valid = 1;
    n = 0;
    do begin cycle(); n++; end while (!s_d1en && n < 40);
    check("t5_write", 32'(s_d1en), 32'd1);
    check("t5_data", 32'(s_d1), 32'h0BEE);
    for (int i = 0; i < 3; i++) begin
      cycle();
      check("t5_drain_hold", 32'(s_state), 32'd5);
    end
    buffer_empty = 1;
    cycle();
    check("t5_drain_d2v", 32'(s_state), 32'd5);
    data_2_valid = 0;
    cycle();
    check("t5_drain_last", 32'(s_state), 32'd5);
    cycle();
    check("t5_idle", 32'(s_state), 32'd0);
    cycle();
    check("t5_stays_idle", 32'(s_state), 32'd0);
    check("t5_no_req", 32'(s_f_en), 32'd0);

    // ---- async reset mid-WAIT, then start_f together with stop ----
    start_f = 1; f_lat = 0;
    wait_req(1'b0, "t6");
    cycle();
    #2;
    rst = 1; model_reset(); f_cnt = 0; t_cnt = 0;
    #1;
    check_all_zero("t6_async");
    @(posedge clk);
    #1;
    rst = 0;
    start_f = 1; stop = 1;
    cycle();
    check("t6_s0", 32'(s_state), 32'd0);
    cycle();
    check("t6_s1", 32'(s_state), 32'd0);
    check("t6_s1_no_req", 32'(s_f_en), 32'd0);
    cycle();
    check("t6_drain", 32'(s_state), 32'd5);
    cycle();
    check("t6_idle", 32'(s_state), 32'd0);
    cycle();
    check("t6_act_f_clear", 32'(s_f_en), 32'd0);
    check("t6_idle2", 32'(s_state), 32'd0);

    // ---- randomized traffic against the model ----
    rand_mode = 1;
    repeat (4000) cycle();
    rand_mode = 0;
    buffer_full = 0; buffer_empty = 1; data_2_valid = 0;
    repeat (5) cycle();

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
